// File: rtl/phy_lane_aligner_if.sv
// Lane aligner receive bus: raw deserializer words and alignment
// controls in, aligned link words and per-lane slip status out.
interface phy_lane_aligner_if #(
    parameter int NUM_LANES    = 16,
    parameter int LANE_WIDTH   = 8,
    parameter int LOG_MAX_SKEW = 2
);
    logic [NUM_LANES*LANE_WIDTH-1:0]   data_in;
    logic [NUM_LANES-1:0]              bit_slip;
    logic [NUM_LANES-1:0]              lane_polarity;
    logic [NUM_LANES*LOG_MAX_SKEW-1:0] lane_skew;
    logic                              reverse_lanes;
    logic [NUM_LANES*LANE_WIDTH-1:0]   data_out;
    logic [NUM_LANES-1:0]              slip_busy;

    modport master (
        output data_in, bit_slip, lane_polarity,
        output lane_skew, reverse_lanes,
        input  data_out, slip_busy
    );

    modport slave (
        input  data_in, bit_slip, lane_polarity,
        input  lane_skew, reverse_lanes,
        output data_out, slip_busy
    );
endinterface

// File: rtl/phy_lane_aligner.sv
// Per-lane bit-slip, polarity and deskew, plus whole-link lane reversal.
// PHY_ALIGNER_SLIP_CNT_EN adds saturating per-lane slip counters.
module phy_lane_aligner #(
    parameter int NUM_LANES    = 16,
    parameter int LANE_WIDTH   = 8,
    parameter int LOG_MAX_SKEW = 2,
    parameter int SLIP_HOLDOFF = 4
) (
    input logic              clk,
    input logic              res_n,
    phy_lane_aligner_if.slave bus
`ifdef PHY_ALIGNER_SLIP_CNT_EN
    ,
    input  logic                   dbg_clear,
    output logic [NUM_LANES*8-1:0] dbg_slip_cnt
`endif
);
    localparam int OW    = $clog2(LANE_WIDTH);
    localparam int HW    = $clog2(SLIP_HOLDOFF + 1);
    localparam int DEPTH = (2 ** LOG_MAX_SKEW) - 1;

    typedef logic [LANE_WIDTH-1:0] word_t;

    logic [NUM_LANES*LANE_WIDTH-1:0] stage_w;
    logic [NUM_LANES-1:0]            busy_w;
`ifdef PHY_ALIGNER_SLIP_CNT_EN
    logic [NUM_LANES*8-1:0]          cnt_w;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        word_t                   din;
        word_t                   prev_q;
        word_t                   sel;
        word_t                   pol;
        word_t                   stg_q;
        word_t                   stg_d;
        word_t                   dl_q [DEPTH];
        logic [2*LANE_WIDTH-1:0] win;
        logic [OW-1:0]           off_q;
        logic [OW-1:0]           off_d;
        logic [HW-1:0]           hc_q;
        logic [HW-1:0]           hc_d;
        logic [LOG_MAX_SKEW-1:0] skew;
        logic                    acc;
        logic                    slip_q;

        assign din  = bus.data_in[i*LANE_WIDTH +: LANE_WIDTH];
        assign skew = bus.lane_skew[i*LOG_MAX_SKEW +: LOG_MAX_SKEW];
        assign win  = {din, prev_q};
        assign sel  = win[off_q +: LANE_WIDTH];
        assign pol  = sel ^ {LANE_WIDTH{bus.lane_polarity[i]}};
        assign acc  = bus.bit_slip[i] && (hc_q == '0);

        // The accepted slip is registered once before it moves the window.
        always_comb begin
            hc_d  = hc_q;
            off_d = off_q;
            stg_d = pol;
            if (acc) begin
                hc_d = HW'(SLIP_HOLDOFF);
            end else if (hc_q != '0) begin
                hc_d = hc_q - 1'b1;
            end
            if (slip_q) begin
                off_d = (off_q == OW'(LANE_WIDTH - 1)) ? '0 : off_q + 1'b1;
            end
            if (skew != '0) begin
                stg_d = dl_q[skew - 1'b1];
            end
        end

        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) begin
                prev_q <= '0;
                off_q  <= '0;
                hc_q   <= '0;
                slip_q <= 1'b0;
                stg_q  <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    dl_q[k] <= '0;
                end
            end else begin
                prev_q  <= din;
                off_q   <= off_d;
                hc_q    <= hc_d;
                slip_q  <= acc;
                stg_q   <= stg_d;
                dl_q[0] <= pol;
                for (int k = 1; k < DEPTH; k++) begin
                    dl_q[k] <= dl_q[k-1];
                end
            end
        end

        assign stage_w[i*LANE_WIDTH +: LANE_WIDTH] = stg_q;
        assign busy_w[i] = (hc_q != '0);

`ifdef PHY_ALIGNER_SLIP_CNT_EN
        logic [7:0] cnt_q;

        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) begin
                cnt_q <= '0;
            end else if (dbg_clear) begin
                cnt_q <= '0;
            end else if (acc && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end

        assign cnt_w[i*8 +: 8] = cnt_q;
`endif
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_rev
        assign bus.data_out[i*LANE_WIDTH +: LANE_WIDTH] =
            bus.reverse_lanes
                ? stage_w[(NUM_LANES-1-i)*LANE_WIDTH +: LANE_WIDTH]
                : stage_w[i*LANE_WIDTH +: LANE_WIDTH];
    end

    assign bus.slip_busy = busy_w;
`ifdef PHY_ALIGNER_SLIP_CNT_EN
    assign dbg_slip_cnt = cnt_w;
`endif
endmodule

// File: tb/tb_phy_lane_aligner.sv
// Scoreboard bench for phy_lane_aligner: two 8-bit lanes, depth-3 deskew,
// slip holdoff of 4; slip counters exercised when the macro is defined.
module tb_phy_lane_aligner;
    logic clk;
    logic res_n;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    phy_lane_aligner_if #(
        .NUM_LANES(2), .LANE_WIDTH(8), .LOG_MAX_SKEW(2)
    ) bus ();

    logic [7:0] cnt_act;
`ifdef PHY_ALIGNER_SLIP_CNT_EN
    logic        dbg_clear;
    logic [15:0] dbg_slip_cnt;
    assign cnt_act = dbg_slip_cnt[7:0];
`else
    assign cnt_act = 8'h00;
`endif

    phy_lane_aligner #(
        .NUM_LANES(2), .LANE_WIDTH(8),
        .LOG_MAX_SKEW(2), .SLIP_HOLDOFF(4)
    ) dut (
        .clk(clk),
        .res_n(res_n),
        .bus(bus)
`ifdef PHY_ALIGNER_SLIP_CNT_EN
        ,
        .dbg_clear(dbg_clear),
        .dbg_slip_cnt(dbg_slip_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] d;
        logic [15:0] dm;
        logic [1:0]  b;
        logic [1:0]  bm;
        logic [7:0]  c;
        logic        cm;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic expect_at(input int due, input logic [15:0] d,
                             input logic [15:0] dm, input logic [1:0] b,
                             input logic [1:0] bm, input string nm);
        exp_t e;
        e.due = due; e.d = d; e.dm = dm; e.b = b; e.bm = bm;
        e.c = 8'h00; e.cm = 1'b0; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic expect_cnt(input int due, input logic [7:0] c,
                              input string nm);
        exp_t e;
        e.due = due; e.d = '0; e.dm = '0; e.b = '0; e.bm = '0;
        e.c = c; e.cm = 1'b1; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: pop every expectation due in this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due < cyc) begin
                checks++;
                $display("FAIL %s: expectation for cycle %0d never sampled",
                         sb[i].name, sb[i].due);
                sb.delete(i);
            end else if (sb[i].due == cyc) begin
                checks++;
                if (((bus.data_out & sb[i].dm) === (sb[i].d & sb[i].dm)) &&
                    ((bus.slip_busy & sb[i].bm) === (sb[i].b & sb[i].bm)) &&
                    (!sb[i].cm || cnt_act === sb[i].c)) begin
                    passes++;
                end else begin
                    $display("FAIL %s @%0d: got data=%h busy=%b cnt=%h, want data=%h mask=%h busy=%b mask=%b cnt=%h",
                             sb[i].name, cyc, bus.data_out, bus.slip_busy,
                             cnt_act, sb[i].d, sb[i].dm, sb[i].b, sb[i].bm,
                             sb[i].c);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        step(1);
        res_n = 1'b1;
    endtask

    function automatic logic [7:0] rot_f0(input int k);
        logic [15:0] w;
        w = 16'hF0F0 >> (k % 8);
        return w[7:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        res_n                = 1'b0;
        bus.data_in          = 16'hFFFF;
        bus.bit_slip         = 2'b11;
        bus.lane_polarity    = 2'b00;
        bus.lane_skew        = 4'b0000;
        bus.reverse_lanes    = 1'b0;
`ifdef PHY_ALIGNER_SLIP_CNT_EN
        dbg_clear            = 1'b0;
`endif
        step(2);
        expect_at(cyc, 16'h0000, 16'hFFFF, 2'b00, 2'b11, "reset_state");
        step(1);
        bus.data_in  = 16'h0000;
        bus.bit_slip = 2'b00;
        step(1);
        res_n = 1'b1;

        // Latency with no skew and zero offset
        step(1);
        t = cyc;
        expect_at(t + 1, 16'h0000, 16'hFFFF, 2'b00, 2'b11, "lat_pre");
        expect_at(t + 2, 16'h0001, 16'hFFFF, 2'b00, 2'b11, "lat_w1");
        expect_at(t + 3, 16'h0002, 16'hFFFF, 2'b00, 2'b11, "lat_w2");
        expect_at(t + 4, 16'h0003, 16'hFFFF, 2'b00, 2'b11, "lat_w3");
        bus.data_in = 16'h0001; step(1);
        bus.data_in = 16'h0002; step(1);
        bus.data_in = 16'h0003; step(1);
        bus.data_in = 16'h0000; step(3);

        // Single slip on a constant F0 stream
        bus.data_in = 16'h00F0;
        step(3);
        t = cyc;
        expect_at(t + 1, 16'h00F0, 16'hFFFF, 2'b01, 2'b11, "slip_busy1");
        expect_at(t + 2, 16'h00F0, 16'hFFFF, 2'b01, 2'b11, "slip_old_sel");
        expect_at(t + 3, 16'h0078, 16'hFFFF, 2'b01, 2'b11, "slip_off1");
        expect_at(t + 4, 16'h0078, 16'hFFFF, 2'b01, 2'b11, "slip_busy4");
        expect_at(t + 5, 16'h0078, 16'hFFFF, 2'b00, 2'b11, "slip_idle");
        bus.bit_slip = 2'b01;
        step(1);
        bus.bit_slip = 2'b00;
        step(5);

        // Seven more slips walk the offset round to zero
        for (int k = 2; k <= 8; k++) begin
            t = cyc;
            expect_at(t + 3, {8'h00, rot_f0(k)}, 16'h00FF, 2'b00, 2'b00,
                      $sformatf("slip_walk%0d", k));
            bus.bit_slip = 2'b01;
            step(1);
            bus.bit_slip = 2'b00;
            step(5);
        end

        // Reset in the middle of holdoff
        t = cyc;
        bus.bit_slip = 2'b01;
        step(1);
        bus.bit_slip = 2'b00;
        expect_at(t + 1, 16'h0000, 16'h0000, 2'b01, 2'b11, "hold_pre_rst");
        step(1);
        res_n = 1'b0;
        expect_at(t + 2, 16'h0000, 16'hFFFF, 2'b00, 2'b11, "hold_rst");
        step(1);
        res_n = 1'b1;

        // Slip held high for 20 cycles
        step(3);
        t = cyc;
        expect_at(t + 5,  16'h0000, 16'h0000, 2'b00, 2'b11, "pace_gap");
        expect_at(t + 6,  16'h0000, 16'h0000, 2'b01, 2'b11, "pace_2nd");
        expect_at(t + 7,  16'h0078, 16'h00FF, 2'b00, 2'b00, "pace_off1");
        expect_at(t + 8,  16'h003C, 16'h00FF, 2'b00, 2'b00, "pace_off2");
        expect_at(t + 21, 16'h0000, 16'h0000, 2'b00, 2'b11, "pace_end");
        expect_at(t + 25, 16'h000F, 16'h00FF, 2'b00, 2'b11, "pace_off4");
        bus.bit_slip = 2'b01;
        step(20);
        bus.bit_slip = 2'b00;
        step(6);
        do_reset();

        // Polarity and reversal
        bus.data_in       = 16'h3CA5;
        bus.lane_polarity = 2'b01;
        bus.reverse_lanes = 1'b1;
        t = cyc;
        expect_at(t + 2, 16'h5A3C, 16'hFFFF, 2'b00, 2'b11, "pol_rev");
        expect_at(t + 3, 16'h5A3C, 16'hFFFF, 2'b00, 2'b11, "pol_rev_hold");
        step(4);
        bus.reverse_lanes = 1'b0;
        expect_at(cyc, 16'h3C5A, 16'hFFFF, 2'b00, 2'b11, "rev_toggle");
        step(1);
        bus.lane_polarity = 2'b00;
        bus.data_in       = 16'h0000;

        // Deskew lane 1 by three words, then reset mid-stream
        bus.lane_skew = 4'b1100;
        step(1);
        do_reset();
        step(2);
        t = cyc;
        expect_at(t + 4, 16'h0000, 16'hFF00, 2'b00, 2'b00, "skew_pre");
        for (int j = 0; j < 10; j++) begin
            logic [7:0] v;
            v = 8'(j + 16);
            expect_at(t + j + 2, {8'h00, v}, 16'h00FF, 2'b00, 2'b00,
                      $sformatf("skew_l0_%0d", j));
            expect_at(t + j + 5, {v, 8'h00}, 16'hFF00, 2'b00, 2'b00,
                      $sformatf("skew_l1_%0d", j));
            bus.data_in = {v, v};
            step(1);
        end
        bus.data_in = 16'h7777;
        expect_at(t + 14, 16'h0077, 16'h00FF, 2'b00, 2'b00, "skew_live");
        step(5);
        res_n = 1'b0;
        expect_at(cyc, 16'h0000, 16'hFFFF, 2'b00, 2'b11, "skew_rst");
        step(1);
        res_n = 1'b1;
        bus.lane_skew = 4'b0000;
        bus.data_in   = 16'h0000;
        step(2);

`ifdef PHY_ALIGNER_SLIP_CNT_EN
        // 300 accepted slips saturate the counter
        bus.bit_slip = 2'b01;
        step(1500);
        bus.bit_slip = 2'b00;
        expect_cnt(cyc, 8'hFF, "cnt_sat");
        step(6);
        t = cyc;
        expect_cnt(t, 8'hFF, "cnt_pre_clr");
        expect_cnt(t + 1, 8'h00, "cnt_clr");
        expect_at(t + 1, 16'h0000, 16'h0000, 2'b01, 2'b01, "cnt_clr_slip");
        expect_cnt(t + 3, 8'h00, "cnt_clr_hold");
        dbg_clear    = 1'b1;
        bus.bit_slip = 2'b01;
        step(1);
        dbg_clear    = 1'b0;
        bus.bit_slip = 2'b00;
        step(3);
`endif

        for (int w = 0; w < 50 && sb.size() != 0; w++) step(1);
        while (sb.size() != 0) begin
            checks++;
            $display("FAIL %s: still pending at end", sb[0].name);
            void'(sb.pop_front());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
